eeprom_access_arbiter: RTL and testbench
========================================

Name: eeprom_access_arbiter

Overview:
Shares the single AT25010 EEPROM command port between several on-chip requesters:
- key loader feeding the auth controller;
- authorized-card-ID list checker;
- provisioning/write path.

It arbitrates round-robin, forwards one command at a time to the EEPROM interface and routes the done/rdata/error response back to the granted requester. A watchdog converts a hung EEPROM transaction into an error response so no requester can block the port forever.

Parameters:
NUM_REQ, 3, number of requesters (2..8); requester i occupies slice i of every packed vector.
WATCHDOG_CYCLES, 32'd100000, max cycles from entering ISSUE to eep_cmd_done; 0 disables the watchdog.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester command request, held until its req_ready pulse.
req_type  in  3*NUM_REQ  command type per requester, bits [3i+2:3i].
req_addr  in  7*NUM_REQ  byte address per requester, bits [7i+6:7i].
req_wdata  in  8*NUM_REQ  write data per requester, bits [8i+7:8i].
req_ready  out  NUM_REQ  one-cycle accept pulse; the command fields were latched on the preceding edge.
resp_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
resp_error  out  NUM_REQ  valid with resp_done: EEPROM error or watchdog expiry.
resp_rdata  out  8  shared read data; updated with resp_done and held until the next response.
grant_id  out  3  index of the current/last granted requester.
busy  out  1  high in ISSUE and WAIT.
eep_cmd_valid  out  1  command valid to the EEPROM interface.
eep_cmd_ready  in  1  EEPROM interface accepts the command.
eep_cmd_type  out  3  latched type.
eep_cmd_addr  out  7  latched address.
eep_cmd_wdata  out  8  latched write data.
eep_cmd_rdata  in  8  read data, valid with eep_cmd_done.
eep_cmd_done  in  1  transaction complete pulse.
eep_cmd_error  in  1  error flag, valid with eep_cmd_done.

Behaviour:
- Reset values: every output 0; state IDLE; last_grant = NUM_REQ-1, so requester 0 wins first; watchdog 0.
- All outputs are registered.
- IDLE, when any req_valid is set:
  - select the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ;
  - latch that requester's type/addr/wdata into eep_cmd_*;
  - grant_id <= i; req_ready[i] <= 1 for exactly one cycle;
  - load watchdog with WATCHDOG_CYCLES; go to ISSUE.
  - req_valid is sampled only in IDLE.
- ISSUE:
  - eep_cmd_valid = 1;
  - on an edge where eep_cmd_valid && eep_cmd_ready: eep_cmd_valid <= 0, go to WAIT.
- WAIT, on eep_cmd_done:
  - resp_rdata <= eep_cmd_rdata;
  - resp_done[grant_id] <= 1 and resp_error[grant_id] <= eep_cmd_error, each for one cycle;
  - last_grant <= grant_id; go to IDLE.
- Watchdog (ISSUE and WAIT, WATCHDOG_CYCLES != 0):
  - decrements once per cycle;
  - when it reaches 1 without done: resp_done and resp_error of the granted requester pulse together, resp_rdata is unchanged, eep_cmd_valid <= 0, last_grant updated, go to IDLE.
  - If done and expiry fall on the same edge, done wins and resp_error = eep_cmd_error.
- eep_cmd_done while in IDLE or ISSUE (late or stray): ignored, no response generated.
- Minimum one IDLE cycle between transactions, so back-to-back grants are at least 1 cycle apart; round-robin guarantees any continuously-valid requester is granted within NUM_REQ transactions.
- A requester still asserting req_valid when the arbiter returns to IDLE is treated as a new request. Requesters must drop valid after seeing req_ready.
- Fields of non-granted requesters never reach eep_cmd_*; eep_cmd_type/addr/wdata hold their value outside ISSUE.
- Reset mid-transaction returns to IDLE immediately and drops eep_cmd_valid; no response is issued for the aborted command.

Test Plan:
- Single read, NUM_REQ=3: req 1 asserts READ (3'b100) addr 7'h10; ready pulses 1 cycle later; model accepts immediately and returns done with rdata 8'hA5 after 20 cycles. Required: resp_done[1]=1 for 1 cycle, resp_rdata=8'hA5, resp_error=0, busy low afterwards.
- Fairness: all three req_valid held continuously, each re-asserted after its done. Required: grant order is 0,1,2,0,1,2 over six transactions, each with correct addr on eep_cmd_addr.
- Backpressure: eep_cmd_ready held low 15 cycles. Required: eep_cmd_valid stays high with stable fields, and the handshake completes on the first ready-high edge.
- Watchdog: WATCHDOG_CYCLES=50, done never asserted. Required: resp_done[2] and resp_error[2] pulse together exactly 50 cycles after entering ISSUE, then IDLE. A later stray done produces no response.
- Error plus simultaneity: done with eep_cmd_error=1 on the same edge as watchdog expiry. Required: a single response with resp_error=1 and rdata captured.
- Reset mid-WAIT: rst_n low for 2 cycles. Required: all outputs 0, and the next request is granted to requester 0 first.

Source files
------------

// File: rtl/eeprom_access_arbiter.sv
// eeprom_access_arbiter
//   Shares one AT25010 EEPROM command port between NUM_REQ on-chip requesters
//   (key loader, card-ID list checker, provisioning writer). Requesters are
//   granted round-robin. One command is in flight at a time, and the response
//   goes back to the granted requester. A watchdog turns a hung transaction
//   into an error response, so no requester can hold the port forever.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   req_valid[i]                request from requester i, held until req_ready[i]
//   req_type/addr/wdata         per-requester command fields, slice i = requester i
//   req_ready[i]                one-cycle accept pulse
//   resp_done/resp_error[i]     one-cycle response pulse (error valid with done)
//   resp_rdata                  shared read data, held until the next response
//   grant_id                    current/last granted requester
//   busy                        transaction in flight (ISSUE or WAIT)
//   eep_cmd_*                   command/response handshake to the EEPROM interface
module eeprom_access_arbiter #(
  parameter int          NUM_REQ         = 3,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_type,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_done,
  output logic [NUM_REQ-1:0]   resp_error,
  output logic [7:0]           resp_rdata,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 eep_cmd_valid,
  input  logic                 eep_cmd_ready,
  output logic [2:0]           eep_cmd_type,
  output logic [6:0]           eep_cmd_addr,
  output logic [7:0]           eep_cmd_wdata,
  input  logic [7:0]           eep_cmd_rdata,
  input  logic                 eep_cmd_done,
  input  logic                 eep_cmd_error
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // Packed per-requester views of the flat field buses.
  logic [NUM_REQ-1:0][2:0] rtype;
  logic [NUM_REQ-1:0][6:0] raddr;
  logic [NUM_REQ-1:0][7:0] rwdata;
  assign rtype  = req_type;
  assign raddr  = req_addr;
  assign rwdata = req_wdata;

  state_t               state, state_d;
  logic [2:0]           last_grant, last_d, grant_d, sel_idx, cand;
  logic                 sel_found, expire, vld_d, busy_d;
  logic [NUM_REQ-1:0]   grant_oh, sel_oh, rdy_d, done_d, err_d;
  logic [31:0]          wdog, wdog_d;
  logic [2:0]           type_d;
  logic [6:0]           addr_d;
  logic [7:0]           wdata_d, rdata_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_oh
    assign grant_oh[i] = (grant_id == 3'(i));
    assign sel_oh[i]   = (sel_idx  == 3'(i));
  end

  // Round-robin pick. The scan runs from the far end down, so the last hit
  // is the first valid requester after last_grant.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = 3'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Expiry fires on the edge where the counter reads 1. A counter loaded
  // with N on ISSUE entry therefore responds exactly N cycles later.
  assign expire = (WATCHDOG_CYCLES != 32'd0) && (wdog == 32'd1);

  always_comb begin
    state_d = state;
    rdy_d   = '0;
    done_d  = '0;
    err_d   = '0;
    vld_d   = eep_cmd_valid;
    grant_d = grant_id;
    last_d  = last_grant;
    wdog_d  = wdog;
    type_d  = eep_cmd_type;
    addr_d  = eep_cmd_addr;
    wdata_d = eep_cmd_wdata;
    rdata_d = resp_rdata;
    if (state != S_IDLE && WATCHDOG_CYCLES != 32'd0 && wdog != 32'd0)
      wdog_d = wdog - 32'd1;
    case (state)
      S_IDLE: begin
        if (sel_found) begin
          state_d = S_ISSUE;
          rdy_d   = sel_oh;
          grant_d = sel_idx;
          type_d  = rtype[sel_idx];
          addr_d  = raddr[sel_idx];
          wdata_d = rwdata[sel_idx];
          vld_d   = 1'b1;
          wdog_d  = WATCHDOG_CYCLES;
        end
      end
      S_ISSUE: begin
        // A done arriving here is stray and is dropped.
        if (expire) begin
          state_d = S_IDLE;
          done_d  = grant_oh;
          err_d   = grant_oh;
          vld_d   = 1'b0;
          last_d  = grant_id;
          wdog_d  = '0;
        end else if (eep_cmd_valid && eep_cmd_ready) begin
          vld_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done takes priority over a same-edge watchdog expiry.
        if (eep_cmd_done) begin
          state_d = S_IDLE;
          rdata_d = eep_cmd_rdata;
          done_d  = grant_oh;
          err_d   = eep_cmd_error ? grant_oh : '0;
          last_d  = grant_id;
          wdog_d  = '0;
        end else if (expire) begin
          state_d = S_IDLE;
          done_d  = grant_oh;
          err_d   = grant_oh;
          last_d  = grant_id;
          wdog_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      last_grant    <= 3'(NUM_REQ - 1);
      wdog          <= '0;
      req_ready     <= '0;
      resp_done     <= '0;
      resp_error    <= '0;
      resp_rdata    <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      eep_cmd_valid <= 1'b0;
      eep_cmd_type  <= '0;
      eep_cmd_addr  <= '0;
      eep_cmd_wdata <= '0;
    end else begin
      state         <= state_d;
      last_grant    <= last_d;
      wdog          <= wdog_d;
      req_ready     <= rdy_d;
      resp_done     <= done_d;
      resp_error    <= err_d;
      resp_rdata    <= rdata_d;
      grant_id      <= grant_d;
      busy          <= busy_d;
      eep_cmd_valid <= vld_d;
      eep_cmd_type  <= type_d;
      eep_cmd_addr  <= addr_d;
      eep_cmd_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Directed bench for eeprom_access_arbiter (NUM_REQ=3, WATCHDOG_CYCLES=50).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_eeprom_access_arbiter;
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [3*NR-1:0] req_type;
  logic [7*NR-1:0] req_addr;
  logic [8*NR-1:0] req_wdata;
  logic [NR-1:0] req_ready, resp_done, resp_error;
  logic [7:0]    resp_rdata;
  logic [2:0]    grant_id;
  logic          busy, eep_cmd_valid, eep_cmd_ready;
  logic [2:0]    eep_cmd_type;
  logic [6:0]    eep_cmd_addr;
  logic [7:0]    eep_cmd_wdata, eep_cmd_rdata;
  logic          eep_cmd_done, eep_cmd_error;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  eeprom_access_arbiter #(.NUM_REQ(NR), .WATCHDOG_CYCLES(32'd50)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_done(resp_done), .resp_error(resp_error),
    .resp_rdata(resp_rdata), .grant_id(grant_id), .busy(busy),
    .eep_cmd_valid(eep_cmd_valid), .eep_cmd_ready(eep_cmd_ready),
    .eep_cmd_type(eep_cmd_type), .eep_cmd_addr(eep_cmd_addr), .eep_cmd_wdata(eep_cmd_wdata),
    .eep_cmd_rdata(eep_cmd_rdata), .eep_cmd_done(eep_cmd_done), .eep_cmd_error(eep_cmd_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [2:0] t, input logic [6:0] a, input logic [7:0] d);
    req_type[3*r +: 3]  = t;
    req_addr[7*r +: 7]  = a;
    req_wdata[8*r +: 8] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},  32'(req_ready), 0);
    chk({tag, "_resp"}, 32'({resp_done, resp_error, resp_rdata}), 0);
    chk({tag, "_gnt"},  32'({grant_id, busy, eep_cmd_valid}), 0);
    chk({tag, "_cmd"},  32'({eep_cmd_type, eep_cmd_addr, eep_cmd_wdata}), 0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    req_valid = '0; eep_cmd_done = 1'b0; eep_cmd_error = 1'b0;
    eep_cmd_rdata = '0; eep_cmd_ready = 1'b1;
    step(); step();
    chk_zero("rst");
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    do begin step(); n++; end while (req_ready == '0 && n < 10);
    chk({tag, "_seen"}, 32'(|req_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_type = '0; req_addr = '0; req_wdata = '0;
    eep_cmd_ready = 1'b1; eep_cmd_rdata = '0; eep_cmd_done = 1'b0; eep_cmd_error = 1'b0;

    // Reset state
    do_reset();

    // Single read from requester 1
    set_req(1, 3'b100, 7'h10, 8'h00);
    req_valid = 3'b010;
    step();
    chk("rd_ready", 32'(req_ready), 32'b010);
    chk("rd_grant", 32'(grant_id), 1);
    chk("rd_cmd", 32'({eep_cmd_valid, eep_cmd_type, eep_cmd_addr}), {22'd0, 1'b1, 3'b100, 7'h10});
    chk("rd_busy", 32'(busy), 1);
    req_valid = '0;
    step();
    chk("rd_hs", 32'({eep_cmd_valid, req_ready}), 0);
    chk("rd_busy_wait", 32'(busy), 1);
    repeat (19) step();
    eep_cmd_done = 1'b1; eep_cmd_rdata = 8'hA5;
    step();
    eep_cmd_done = 1'b0;
    chk("rd_done", 32'({resp_done, resp_error}), 32'b010_000);
    chk("rd_rdata", 32'(resp_rdata), 32'hA5);
    chk("rd_idle", 32'(busy), 0);
    step();
    chk("rd_pulse", 32'(resp_done), 0);
    chk("rd_hold", 32'(resp_rdata), 32'hA5);

    // Fairness: all requesters held valid, re-asserted after each done
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 3'b100, 7'(7'h20 + i), 8'h00);
    req_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      int e;
      e = n % NR;
      wait_rdy("rr");
      chk("rr_grant", 32'(grant_id), 32'(e));
      chk("rr_ready", 32'(req_ready), 32'(1 << e));
      chk("rr_addr", 32'(eep_cmd_addr), 32'(7'h20 + e));
      req_valid[e] = 1'b0;
      step();
      eep_cmd_done = 1'b1; eep_cmd_rdata = 8'(n);
      step();
      eep_cmd_done = 1'b0;
      chk("rr_done", 32'(resp_done), 32'(1 << e));
      chk("rr_rdata", 32'(resp_rdata), 32'(n));
      req_valid[e] = 1'b1;
    end
    req_valid = '0;

    // Backpressure: ready low for 15 cycles. A competing requester must not
    // leak into the latched fields.
    do_reset();
    eep_cmd_ready = 1'b0;
    set_req(0, 3'b010, 7'h33, 8'h5C);
    set_req(1, 3'b111, 7'h7F, 8'hFF);
    req_valid = 3'b001;
    step();
    chk("bp_grant", 32'({grant_id, req_ready}), 32'({3'd0, 3'b001}));
    req_valid = 3'b010;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("bp_hold", 32'({eep_cmd_valid, eep_cmd_type, eep_cmd_addr, eep_cmd_wdata}),
          32'({1'b1, 3'b010, 7'h33, 8'h5C}));
    end
    eep_cmd_ready = 1'b1;
    step();
    chk("bp_hs", 32'({eep_cmd_valid, busy}), 32'b01);
    eep_cmd_done = 1'b1; eep_cmd_rdata = 8'h77;
    step();
    eep_cmd_done = 1'b0;
    chk("bp_done", 32'(resp_done), 32'b001);
    req_valid = '0;

    // Watchdog expiry with no done, then a stray done
    do_reset();
    set_req(2, 3'b100, 7'h05, 8'h00);
    req_valid = 3'b100;
    step();
    chk("wd_grant", 32'(grant_id), 2);
    req_valid = '0;
    eep_cmd_rdata = 8'hEE;
    for (int k = 1; k <= 49; k++) begin
      step();
      chk("wd_quiet", 32'({resp_done, resp_error}), 0);
    end
    step();
    chk("wd_fire", 32'({resp_done, resp_error}), 32'b100_100);
    chk("wd_rdata", 32'(resp_rdata), 0);
    chk("wd_idle", 32'({busy, eep_cmd_valid}), 0);
    eep_cmd_done = 1'b1;
    step();
    eep_cmd_done = 1'b0;
    chk("wd_stray1", 32'(resp_done), 0);
    step();
    chk("wd_stray2", 32'({resp_done, busy}), 0);

    // Done with error on the same edge as expiry
    do_reset();
    set_req(0, 3'b100, 7'h0A, 8'h00);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    repeat (49) step();
    eep_cmd_done = 1'b1; eep_cmd_error = 1'b1; eep_cmd_rdata = 8'h3C;
    step();
    eep_cmd_done = 1'b0; eep_cmd_error = 1'b0;
    chk("sim_resp", 32'({resp_done, resp_error}), 32'b001_001);
    chk("sim_rdata", 32'(resp_rdata), 32'h3C);
    step();
    chk("sim_single", 32'(resp_done), 0);

    // Reset mid-WAIT: last_grant must return to NUM_REQ-1
    do_reset();
    set_req(0, 3'b100, 7'h01, 8'h00);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    eep_cmd_done = 1'b1; eep_cmd_rdata = 8'h11;
    step();
    eep_cmd_done = 1'b0;
    step();
    set_req(1, 3'b100, 7'h44, 8'h00);
    req_valid = 3'b010;
    step();
    chk("mr_grant1", 32'(grant_id), 1);
    req_valid = '0;
    step();
    chk("mr_wait", 32'(busy), 1);
    rst_n = 1'b0;
    step(); step();
    chk_zero("mr");
    rst_n = 1'b1;
    step();
    req_valid = 3'b111;
    step();
    chk("mr_first", 32'({grant_id, req_ready}), 32'({3'd0, 3'b001}));
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
